dpram_pipe: RTL and testbench

DPRAM_PIPE -- requirements
Module: dpram_pipe

---
 rtl/dpram_pipe_pkg.sv | 16 +
 rtl/dpram_rd_pipe.sv | 48 ++++
 rtl/dpram_pipe.sv | 129 ++++++++++++
 tb/tb_dpram_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pipe_pkg.sv
// dpram_pipe_pkg: shared types and constants for the heapsort dual-port RAM.
// Holds the sweep FSM encoding and the legal read-latency / write-mode values.
package dpram_pipe_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RD_LAT_MIN     = 1;
    localparam int RD_LAT_MAX     = 2;

    localparam int WM_WRITE_FIRST = 0;
    localparam int WM_READ_FIRST  = 1;

endpackage

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe: per-port read output stage, one or two registers deep.
// Ports: clk, rst, en/d (read request + array data), q/qv (registered data + valid).
module dpram_rd_pipe
    import dpram_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = RD_LAT_MIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  qv
);

    logic [DATA_WIDTH-1:0] d1;
    logic                  v1;

    generate
        if (RD_LATENCY == RD_LAT_MAX) begin : g_two
            always_ff @(posedge clk) begin
                if (rst) begin
                    v1 <= 1'b0;
                    d1 <= '0;
                end else begin
                    v1 <= en;
                    if (en) d1 <= d;
                end
            end
        end else begin : g_one
            assign v1 = en;
            assign d1 = d;
        end
    endgenerate

    // q only moves on a valid read so it holds its last value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            qv <= 1'b0;
        end else begin
            qv <= v1;
            if (v1) q <= d1;
        end
    end

endmodule

// File: rtl/dpram_pipe.sv
// dpram_pipe: true dual-port RAM with zeroing init sweep and collision tracking.
// Ports: clk, rst, data/we/re/addr per port, q/qv per port, ready, coll, coll_cnt.
module dpram_pipe
    import dpram_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEVEL      = 1,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LATENCY = RD_LAT_MIN,
    parameter int WRITE_MODE = WM_WRITE_FIRST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic                  re_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  qv_a,
    output logic                  qv_b,
    output logic                  ready,
    output logic                  coll,
    output logic [15:0]           coll_cnt
);

    localparam int DEPTH = 1 << LEVEL;
    localparam int IW    = (LEVEL > 0) ? LEVEL : 1;
    localparam logic [IW-1:0]         ILAST = IW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(DEPTH - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   cnt;
    logic [IW-1:0]   ia, ib;
    logic            run, hit, wr_a, wr_b, coll_now;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] ram [DEPTH];

    // Upper address bits are masked off; DEPTH 1 collapses every index to 0.
    assign ia = IW'(addr_a & AMASK);
    assign ib = IW'(addr_b & AMASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT: if (cnt == ILAST) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
        endcase
    end

    assign ready    = (state == ST_RUN);
    assign run      = ready && !rst;
    assign hit      = we_a && we_b && (ia == ib);
    assign coll_now = run && hit;
    assign wr_a     = run && we_a;
    assign wr_b     = run && we_b && !hit;

    always_ff @(posedge clk) begin
        if (!rst && state == ST_INIT) begin
            ram[cnt] <= '0;
        end else begin
            if (wr_a) ram[ia] <= data_a;
            if (wr_b) ram[ib] <= data_b;
        end
    end

    // Forwarding outside the array; port A is applied last so it wins a collision.
    always_comb begin
        rd_a = ram[ia];
        rd_b = ram[ib];
        if (WRITE_MODE == WM_WRITE_FIRST) begin
            if (wr_b && ib == ia) rd_a = data_b;
            if (wr_a)             rd_a = data_a;
            if (wr_b)             rd_b = data_b;
            if (wr_a && ia == ib) rd_b = data_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= coll_now;
            if (coll_now && coll_cnt != 16'hFFFF)
                coll_cnt <= coll_cnt + 16'd1;
        end
    end

    dpram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LATENCY(RD_LATENCY)
    ) u_pipe_a (
        .clk(clk),
        .rst(rst),
        .en (run && re_a),
        .d  (rd_a),
        .q  (q_a),
        .qv (qv_a)
    );

    dpram_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LATENCY(RD_LATENCY)
    ) u_pipe_b (
        .clk(clk),
        .rst(rst),
        .en (run && re_b),
        .d  (rd_b),
        .q  (q_b),
        .qv (qv_b)
    );

endmodule

// File: tb/tb_dpram_pipe.sv
// tb_dpram_pipe: scoreboard bench driving three dpram_pipe variants in lockstep.
// u0: latency 1 write-first, u1: latency 1 read-first, u2: latency 2 write-first.
module tb_dpram_pipe;

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_a, data_b;
    logic        we_a, we_b, re_a, re_b;
    logic [4:0]  addr_a, addr_b;

    logic [31:0] qa [3];
    logic [31:0] qb [3];
    logic        qva [3];
    logic        qvb [3];
    logic        rdy [3];
    logic        cl [3];
    logic [15:0] ccnt [3];

    exp_t        sb [6][$];
    logic [31:0] last [6];
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 0;
    bit          tb_run = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    dpram_pipe #(.DATA_WIDTH(32), .LEVEL(3), .ADDR_WIDTH(5),
                 .RD_LATENCY(1), .WRITE_MODE(0)) u0 (
        .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
        .we_a(we_a), .we_b(we_b), .re_a(re_a), .re_b(re_b),
        .addr_a(addr_a), .addr_b(addr_b), .q_a(qa[0]), .q_b(qb[0]),
        .qv_a(qva[0]), .qv_b(qvb[0]), .ready(rdy[0]), .coll(cl[0]),
        .coll_cnt(ccnt[0]));

    dpram_pipe #(.DATA_WIDTH(32), .LEVEL(3), .ADDR_WIDTH(5),
                 .RD_LATENCY(1), .WRITE_MODE(1)) u1 (
        .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
        .we_a(we_a), .we_b(we_b), .re_a(re_a), .re_b(re_b),
        .addr_a(addr_a), .addr_b(addr_b), .q_a(qa[1]), .q_b(qb[1]),
        .qv_a(qva[1]), .qv_b(qvb[1]), .ready(rdy[1]), .coll(cl[1]),
        .coll_cnt(ccnt[1]));

    dpram_pipe #(.DATA_WIDTH(32), .LEVEL(3), .ADDR_WIDTH(5),
                 .RD_LATENCY(2), .WRITE_MODE(0)) u2 (
        .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b),
        .we_a(we_a), .we_b(we_b), .re_a(re_a), .re_b(re_b),
        .addr_a(addr_a), .addr_b(addr_b), .q_a(qa[2]), .q_b(qb[2]),
        .qv_a(qva[2]), .qv_b(qvb[2]), .ready(rdy[2]), .coll(cl[2]),
        .coll_cnt(ccnt[2]));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, queue expected read data, advance past the edge.
    // ea0/eb0 apply to write-first duts, ea1/eb1 to the read-first dut.
    task automatic step(input logic [31:0] r,
                        input logic [31:0] wa, input logic [31:0] aa,
                        input logic [31:0] da, input logic [31:0] ra,
                        input logic [31:0] wb, input logic [31:0] ab,
                        input logic [31:0] db, input logic [31:0] rb,
                        input logic [31:0] ea0, input logic [31:0] ea1,
                        input logic [31:0] eb0, input logic [31:0] eb1);
        int   e;
        int   lat;
        exp_t x;
        rst    = r[0];
        we_a   = wa[0];
        addr_a = aa[4:0];
        data_a = da;
        re_a   = ra[0];
        we_b   = wb[0];
        addr_b = ab[4:0];
        data_b = db;
        re_b   = rb[0];
        e = edge_n + 1;
        for (int d = 0; d < 3; d++) begin
            lat = (d == 2) ? 2 : 1;
            if (r[0]) begin
                // reads that would complete at or after the reset edge are lost
                for (int p = 0; p < 2; p++) begin
                    while (sb[d*2+p].size() > 0 &&
                           sb[d*2+p][sb[d*2+p].size()-1].due >= e)
                        void'(sb[d*2+p].pop_back());
                end
            end else if (tb_run) begin
                if (ra[0]) begin
                    x.due = e + lat - 1;
                    x.d   = (d == 1) ? ea1 : ea0;
                    sb[d*2].push_back(x);
                end
                if (rb[0]) begin
                    x.due = e + lat - 1;
                    x.d   = (d == 1) ? eb1 : eb0;
                    sb[d*2+1].push_back(x);
                end
            end
        end
        @(posedge clk);
        #1;
        if (r[0]) begin
            tb_run = 0;
            for (int k = 0; k < 6; k++) last[k] = '0;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sweep(input string tag);
        for (int i = 1; i <= 8; i++) begin
            if (tag == "init" && i == 2)
                step(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
            else if (tag == "init" && i == 6)
                step(0, 1, 3, 32'h55, 0, 1, 3, 32'h66, 0, 0, 0, 0, 0);
            else
                idle();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s_ready_c%0d_u%0d", tag, i, d),
                    32'(rdy[d]), 32'(i == 8));
                if (i == 6)
                    chk($sformatf("%s_coll_u%0d", tag, d), 32'(cl[d]), 0);
            end
        end
        tb_run = 1;
    endtask

    logic        m_v;
    logic [31:0] m_q;
    exp_t        m_x;

    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 6; k++) begin
                m_v = (k % 2 == 0) ? qva[k/2] : qvb[k/2];
                m_q = (k % 2 == 0) ? qa[k/2]  : qb[k/2];
                checks++;
                if (m_v) begin
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_qv u%0d port%0d: q=%h with no read outstanding",
                                 k/2, k%2, m_q);
                    end else begin
                        m_x = sb[k].pop_front();
                        if (m_x.due != edge_n || m_q !== m_x.d) begin
                            errors++;
                            $display("FAIL read u%0d port%0d: got %h at edge %0d, expected %h at edge %0d",
                                     k/2, k%2, m_q, edge_n, m_x.d, m_x.due);
                        end
                    end
                    last[k] = m_q;
                end else if (m_q !== last[k]) begin
                    errors++;
                    $display("FAIL hold u%0d port%0d: got %h expected %h",
                             k/2, k%2, m_q, last[k]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] b2b [4];
    int          n;
    bit          pend;

    initial begin
        b2b[0] = 32'h0;
        b2b[1] = 32'hBB;
        b2b[2] = 32'hDEADBEEF;
        b2b[3] = 32'h33;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mon_on = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ready_u%0d", d), 32'(rdy[d]), 0);
            chk($sformatf("rst_ccnt_u%0d", d), 32'(ccnt[d]), 0);
        end
        sweep("init");

        for (int i = 0; i < 8; i++)
            step(0, 0, i, 0, 1, 0, 7 - i, 0, 1, 0, 0, 0, 0);

        step(0, 1, 2, 32'hDEADBEEF, 0, 1, 5, 32'h12345678, 0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++)
            chk($sformatf("dual_coll_u%0d", d), 32'(cl[d]), 0);
        step(0, 0, 10, 0, 1, 0, 5, 0, 1,
             32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'h12345678);

        step(0, 1, 4, 32'h11, 0, 1, 4, 32'h22, 0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("coll_pulse_u%0d", d), 32'(cl[d]), 1);
            chk($sformatf("coll_cnt1_u%0d", d), 32'(ccnt[d]), 1);
        end
        step(0, 0, 4, 0, 1, 0, 0, 0, 0, 32'h11, 32'h11, 0, 0);
        for (int d = 0; d < 3; d++)
            chk($sformatf("coll_end_u%0d", d), 32'(cl[d]), 0);

        step(0, 1, 1, 32'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'hBB, 0, 0, 1, 0, 1, 0, 0, 32'hBB, 32'hAA);
        step(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'hBB, 32'hBB, 0, 0);

        step(0, 1, 6, 32'h66, 1, 1, 6, 32'h77, 0, 32'h66, 32'h0, 0, 0);
        for (int d = 0; d < 3; d++)
            chk($sformatf("coll_cnt2_u%0d", d), 32'(ccnt[d]), 2);
        step(0, 0, 6, 0, 0, 1, 3, 32'h33, 1, 0, 0, 32'h33, 32'h0);

        for (int i = 0; i < 4; i++)
            step(0, 0, i, 0, 1, 0, 0, 0, 0, b2b[i], b2b[i], 0, 0);
        idle();
        idle();
        idle();

        step(0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 7, 0, 1, 0, 7, 0, 1, 32'h77, 32'h77, 32'h77, 32'h77);
        step(0, 0, 7, 0, 1, 0, 0, 0, 0, 32'h77, 32'h77, 0, 0);
        step(1, 0, 7, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mid_rst_ready_u%0d", d), 32'(rdy[d]), 0);
            chk($sformatf("mid_rst_ccnt_u%0d", d), 32'(ccnt[d]), 0);
            chk($sformatf("mid_rst_coll_u%0d", d), 32'(cl[d]), 0);
        end
        sweep("resweep");
        step(0, 0, 7, 0, 1, 0, 2, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 4, 0, 1, 0, 0, 0, 0);

        n = 0;
        pend = 1;
        while (pend && n < 20) begin
            idle();
            n++;
            pend = 0;
            for (int k = 0; k < 6; k++)
                if (sb[k].size() != 0) pend = 1;
        end
        checks++;
        if (pend) begin
            errors++;
            $display("FAIL drain: reads still outstanding after %0d cycles, expected none", n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
